// File: rtl/oven_button_conditioner.sv
// Panel button conditioner: 2-flop sync, debounce, press/release pulses and optional auto-repeat.
// Auto-repeat is built only when OVEN_BTN_AUTO_REPEAT_EN is defined.
module oven_button_conditioner #(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_PERIOD   = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b00110
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int             CW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DEB_TC = CW'(DEBOUNCE_CYCLES - 1);

`ifdef OVEN_BTN_AUTO_REPEAT_EN
  localparam int             RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int             RW     = (RMAX < 2) ? 1 : $clog2(RMAX);
  localparam logic [RW-1:0] DLY_TC = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_TC = RW'(REPEAT_PERIOD - 1);

  // state     | meaning
  // RELEASED  | button up (or not repeat-capable), no repeat pending
  // HOLD_WAIT | pressed, counting the initial delay to the first repeat
  // REPEATING | held past the delay, repeat pulse every period
  typedef enum logic [1:0] {RELEASED, HOLD_WAIT, REPEATING} rep_state_t;
`endif

  logic [N_BTN-1:0] s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [CW-1:0] cnt;
    logic          level, press_q, release_q, repeat_q;
    logic          acc_press, acc_release, fire;

    assign acc_press   = (s2[i] != level) && (cnt == DEB_TC) &&  s2[i];
    assign acc_release = (s2[i] != level) && (cnt == DEB_TC) && !s2[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (s2[i] == level) begin
        cnt <= '0;
      end else if (cnt == DEB_TC) begin
        level <= s2[i];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

`ifdef OVEN_BTN_AUTO_REPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rep
      rep_state_t    state, state_nx;
      logic [RW-1:0] rcnt, rcnt_nx;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state <= RELEASED;
          rcnt  <= '0;
        end else begin
          state <= state_nx;
          rcnt  <= rcnt_nx;
        end
      end

      always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt + 1'b1;
        if (acc_release) begin
          state_nx = RELEASED;
          rcnt_nx  = '0;
        end else begin
          case (state)
            RELEASED: begin
              rcnt_nx = '0;
              if (acc_press) state_nx = HOLD_WAIT;
            end
            HOLD_WAIT: begin
              if (rcnt == DLY_TC) begin
                state_nx = REPEATING;
                rcnt_nx  = '0;
              end
            end
            REPEATING: begin
              if (rcnt == PER_TC) rcnt_nx = '0;
            end
            default: begin
              state_nx = RELEASED;
              rcnt_nx  = '0;
            end
          endcase
        end
      end

      // A release accepted on the same edge wins over a due repeat.
      always_comb begin
        fire = 1'b0;
        if (!acc_release) begin
          fire = ((state == HOLD_WAIT) && (rcnt == DLY_TC)) ||
                 ((state == REPEATING) && (rcnt == PER_TC));
        end
      end
    end else begin : g_no_rep
      assign fire = 1'b0;
    end
`else
    assign fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= acc_press | fire;
        release_q <= acc_release;
        repeat_q  <= fire;
      end
    end

    assign btn_level[i]   = level;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_oven_button_conditioner.sv
// Bench for oven_button_conditioner: directed scenarios with literal expectations plus
// randomized bouncing inputs compared every cycle against a sample-window reference model.
`timescale 1ns/1ps
module tb_oven_button_conditioner;
  localparam int         N    = 5;
  localparam int         DEB  = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam logic [4:0] MASK = 5'b00110;
`ifdef OVEN_BTN_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

  always #5 clk = ~clk;

  oven_button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  int checks = 0;
  int errors = 0;

  // Reference: raw samples taken at each edge; the level flips once the DEB samples
  // ending two edges ago (synchroniser delay) all disagree with it.
  logic [N-1:0] rawq[$];
  logic [N-1:0] m_level, m_press, m_release, m_repeat;
  int           tp[N];
  int           cyc;

  task automatic model_clear();
    rawq.delete();
    for (int j = 0; j < DEB + 2; j++) rawq.push_back('0);
    m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
    for (int b = 0; b < N; b++) tp[b] = 0;
    cyc = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] dummy;
    bit all_hi, all_lo;
    rawq.push_back(btn_raw);
    dummy = rawq.pop_front();
    m_press = '0; m_release = '0; m_repeat = '0;
    for (int b = 0; b < N; b++) begin
      all_hi = 1'b1; all_lo = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        if (rawq[j][b]) all_lo = 1'b0;
        else            all_hi = 1'b0;
      end
      if (!m_level[b] && all_hi) begin
        m_level[b] = 1'b1; m_press[b] = 1'b1; tp[b] = cyc;
      end else if (m_level[b] && all_lo) begin
        m_level[b] = 1'b0; m_release[b] = 1'b1;
      end else if (REP_EN && MASK[b] && m_level[b] && (cyc - tp[b] >= RD) &&
                   ((cyc - tp[b] - RD) % RP == 0)) begin
        m_press[b] = 1'b1; m_repeat[b] = 1'b1;
      end
    end
    cyc++;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (!rst_n) model_clear();
      else        model_step();
      #1;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat} !==
          {m_level, m_press, m_release, m_repeat}) begin
        errors++;
        $display("FAIL model cyc=%0d got lvl=%b prs=%b rel=%b rep=%b want lvl=%b prs=%b rel=%b rep=%b",
                 cyc, btn_level, btn_press, btn_release, btn_repeat,
                 m_level, m_press, m_release, m_repeat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic count_pulses(input int n, input int b, output int np, output int nr);
    np = 0; nr = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (btn_press[b])   np++;
      if (btn_release[b]) nr++;
    end
  endtask

  int np, nr, hold[N];

  initial begin
    repeat (3) tick();
    chk("reset_out", {btn_level, btn_press, btn_release, btn_repeat}, 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    btn_raw[0] = 1'b1;
    repeat (5) tick();
    chk("clean_pre_level", btn_level[0], 1'b0);
    tick();
    chk("clean_press", btn_press, 5'b00001);
    chk("clean_level", btn_level[0], 1'b1);
    chk("clean_norep", btn_repeat, 5'b00000);
    count_pulses(30, 0, np, nr);
    chk("hold0_extra_press", np, 0);
    btn_raw[0] = 1'b0;
    count_pulses(10, 0, np, nr);
    chk("rel0_count", nr, 1);
    chk("rel0_press", np, 0);

    btn_raw[1] = 1'b1; tick(); tick();
    btn_raw[1] = 1'b0; tick();
    btn_raw[1] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("bounce_early", btn_press[1], 1'b0);
    end
    tick();
    chk("bounce_press", btn_press[1], 1'b1);
    chk("bounce_norep", btn_repeat[1], 1'b0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk("rep_press", btn_press[1], REP_EN && k >= 10 && ((k - 10) % 3 == 0));
      chk("rep_flag", btn_repeat[1], REP_EN && k >= 10 && ((k - 10) % 3 == 0));
    end

    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", {btn_level, btn_press, btn_release, btn_repeat}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("rst_repress", btn_press[1], e == 6);
      if (e == 6) chk("rst_repress_norep", btn_repeat[1], 1'b0);
    end
    btn_raw[1] = 1'b0;
    repeat (12) tick();

    btn_raw[2:1] = 2'b11;
    repeat (5) tick();
    chk("simul_early", btn_press, 5'b00000);
    tick();
    chk("simul_press", btn_press, 5'b00110);
    btn_raw = '0;
    repeat (12) tick();

    for (int b = 0; b < N; b++) hold[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++) begin
        if (hold[b] == 0) begin
          btn_raw[b] = ~btn_raw[b];
          hold[b] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1))
                                                : int'($urandom_range(40, 4));
        end else begin
          hold[b]--;
        end
      end
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(799, 0) == 0) rst_n = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
